vm_dispense_sequencer: RTL and testbench

Sequences the physical back end of the vending machine once the vending core has completed a sale.
- Drives the selected product-slot motor.
- Confirms the drop on the drop sensor.
- Pays out change coin by coin through the hopper.
- Reports jams and an empty hopper as sticky faults.
- Sits between the vending core's prod/balance outputs and the motor, sensor and hopper I/O.

---
 rtl/vm_pkg.sv | 29 ++
 rtl/vm_cycle_timer.sv | 28 ++
 rtl/vm_dispense_sequencer.sv | 178 +++++++++++++++++
 tb/tb_vm_dispense_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine dispense back end.
// Also used by the vending core for its prod/balance widths.
package vm_pkg;

  localparam int PROD_W = 3;
  localparam int CHG_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    WAIT_DROP,
    COIN_HI,
    COIN_LO,
    DONE,
    FAULT
  } state_e;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_JAM     = 2'b01;
  localparam logic [1:0] FLT_EMPTY   = 2'b10;
  localparam logic [1:0] FLT_BADPROD = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vm_cycle_timer.sv
// Loadable down-counter shared by the motor, drop-wait and coin phases.
// Loading N makes expired high in the Nth cycle after the load edge.
module vm_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)                count_d = value;
    else if (count_q != '0)  count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign expired = (count_q <= W'(1));

endmodule

// File: rtl/vm_dispense_sequencer.sv
// Back-end sequencer: runs the slot motor, confirms the drop, pays change
// coin by coin and latches jam / empty-hopper / bad-code faults.
module vm_dispense_sequencer
  import vm_pkg::*;
#(
  parameter int NUM_SLOTS    = 6,
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 16,
  parameter int COIN_PULSE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PROD_W-1:0] req_prod,
  input  logic [CHG_W-1:0]  req_change,
  output logic              motor_on,
  output logic [PROD_W-1:0] motor_sel,
  input  logic              drop_sense,
  output logic              hopper_pulse,
  input  logic              hopper_empty,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  input  logic              fault_clr,
  output logic [CHG_W-1:0]  change_owed
);

  localparam int TW = $clog2(max3(MOTOR_CYCLES, DROP_TIMEOUT, COIN_PULSE)) + 1;
  localparam logic [PROD_W-1:0] MAX_PROD = PROD_W'(NUM_SLOTS);

  state_e            state_q, state_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [CHG_W-1:0]  remaining_q, remaining_d;
  logic              drop_seen_q, drop_seen_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [CHG_W-1:0]  change_owed_q, change_owed_d;
  logic              motor_on_q, motor_on_d;
  logic [PROD_W-1:0] motor_sel_q, motor_sel_d;
  logic              hopper_pulse_q, hopper_pulse_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_expired;

  vm_cycle_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_expired)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    prod_d        = prod_q;
    remaining_d   = remaining_q;
    drop_seen_d   = drop_seen_q;
    fault_code_d  = fault_code_q;
    change_owed_d = change_owed_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          prod_d      = req_prod;
          remaining_d = req_change;
          drop_seen_d = 1'b0;
          if (req_prod > MAX_PROD) begin
            state_d       = FAULT;
            fault_code_d  = FLT_BADPROD;
            change_owed_d = req_change;
          end else if (req_prod != '0)   state_d = MOTOR;
          else if (req_change != '0)     state_d = COIN_HI;
          else                           state_d = DONE;
        end
      end
      MOTOR: begin
        drop_seen_d = drop_seen_q | drop_sense;
        if (tmr_expired) begin
          if (drop_seen_d) state_d = (remaining_q != '0) ? COIN_HI : DONE;
          else             state_d = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (drop_sense) state_d = (remaining_q != '0) ? COIN_HI : DONE;
        else if (tmr_expired) begin
          state_d       = FAULT;
          fault_code_d  = FLT_JAM;
          change_owed_d = remaining_q;
        end
      end
      COIN_HI: begin
        if (tmr_expired) begin
          state_d = COIN_LO;
          if (remaining_q != '0) remaining_d = remaining_q - CHG_W'(1);
        end
      end
      COIN_LO: begin
        if (tmr_expired) state_d = (remaining_q == '0) ? DONE : COIN_HI;
      end
      DONE:    state_d = IDLE;
      FAULT: begin
        if (fault_clr) begin
          state_d       = IDLE;
          fault_code_d  = FLT_NONE;
          change_owed_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // The hopper is checked on the edge that would start a coin, so an empty
    // hopper never produces even a partial pulse.
    if (state_d == COIN_HI && state_q != COIN_HI && hopper_empty) begin
      state_d       = FAULT;
      fault_code_d  = FLT_EMPTY;
      change_owed_d = remaining_d;
    end

    tmr_load = (state_d != state_q);
    case (state_d)
      MOTOR:            tmr_val = TW'(MOTOR_CYCLES);
      WAIT_DROP:        tmr_val = TW'(DROP_TIMEOUT);
      COIN_HI, COIN_LO: tmr_val = TW'(COIN_PULSE);
      default:          tmr_val = '0;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up cycle-for-cycle with the state they describe.
    motor_on_d     = (state_d == MOTOR);
    motor_sel_d    = motor_on_d ? prod_d : '0;
    hopper_pulse_d = (state_d == COIN_HI);
    done_d         = (state_d == DONE);
    fault_d        = (state_d == FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      prod_q         <= '0;
      remaining_q    <= '0;
      drop_seen_q    <= 1'b0;
      fault_code_q   <= FLT_NONE;
      change_owed_q  <= '0;
      motor_on_q     <= 1'b0;
      motor_sel_q    <= '0;
      hopper_pulse_q <= 1'b0;
      done_q         <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      prod_q         <= prod_d;
      remaining_q    <= remaining_d;
      drop_seen_q    <= drop_seen_d;
      fault_code_q   <= fault_code_d;
      change_owed_q  <= change_owed_d;
      motor_on_q     <= motor_on_d;
      motor_sel_q    <= motor_sel_d;
      hopper_pulse_q <= hopper_pulse_d;
      done_q         <= done_d;
      fault_q        <= fault_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign motor_on     = motor_on_q;
  assign motor_sel    = motor_sel_q;
  assign hopper_pulse = hopper_pulse_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;
  assign change_owed  = change_owed_q;

endmodule

// File: tb/tb_vm_dispense_sequencer.sv
// Directed bench for vm_dispense_sequencer with default parameters.
// Cycle k = k-th negedge sample after the accepting posedge.
module tb_vm_dispense_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_prod;
  logic [2:0] req_change;
  logic       motor_on;
  logic [2:0] motor_sel;
  logic       drop_sense;
  logic       hopper_pulse;
  logic       hopper_empty;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;
  logic       fault_clr;
  logic [2:0] change_owed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vm_dispense_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_prod     (req_prod),
    .req_change   (req_change),
    .motor_on     (motor_on),
    .motor_sel    (motor_sel),
    .drop_sense   (drop_sense),
    .hopper_pulse (hopper_pulse),
    .hopper_empty (hopper_empty),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .fault_clr    (fault_clr),
    .change_owed  (change_owed)
  );

  // Presents a request at a negedge, lets the next posedge accept it and
  // returns at the following negedge (cycle 1).
  task automatic accept(input logic [2:0] p, input logic [2:0] c, input string name);
    @(negedge clk);
    req_valid = 1'b1; req_prod = p; req_change = c;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept: req_ready=%b want 1", name, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_prod = 3'd0; req_change = 3'd0;
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({req_ready, motor_on, motor_sel, hopper_pulse, done, fault, fault_code, change_owed} !== 13'b1_0_000_0_0_0_00_000) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b motor=%b sel=%0d pulse=%b done=%b fault=%b code=%0d owed=%0d want ready=1 rest 0",
               req_ready, motor_on, motor_sel, hopper_pulse, done, fault, fault_code, change_owed);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_change_only();
    logic exp_pulse;
    accept(3'd0, 3'd3, "change_only");
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge clk);
      exp_pulse = (k <= 12) && (((k - 1) % 4) < 2);
      checks++;
      if (hopper_pulse !== exp_pulse) begin
        errors++; $display("FAIL change_only pulse cyc%0d: got %b want %b", k, hopper_pulse, exp_pulse);
      end
      checks++;
      if (done !== (k == 13)) begin
        errors++; $display("FAIL change_only done cyc%0d: got %b want %b", k, done, (k == 13));
      end
      checks++;
      if (motor_on !== 1'b0) begin
        errors++; $display("FAIL change_only motor cyc%0d: got %b want 0", k, motor_on);
      end
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL change_only ready_after: got %b want 1", req_ready);
    end
  endtask

  task automatic test_product_drop();
    accept(3'd2, 3'd0, "product_drop");
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      drop_sense = (k == 4);
      checks++;
      if (motor_on !== (k <= 8)) begin
        errors++; $display("FAIL product_drop motor cyc%0d: got %b want %b", k, motor_on, (k <= 8));
      end
      checks++;
      if (motor_sel !== ((k <= 8) ? 3'd2 : 3'd0)) begin
        errors++; $display("FAIL product_drop sel cyc%0d: got %0d want %0d", k, motor_sel, (k <= 8) ? 2 : 0);
      end
      checks++;
      if (done !== (k == 9)) begin
        errors++; $display("FAIL product_drop done cyc%0d: got %b want %b", k, done, (k == 9));
      end
    end
    drop_sense = 1'b0;
  endtask

  task automatic test_jam();
    accept(3'd5, 3'd2, "jam");
    for (int k = 1; k <= 27; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (motor_on !== (k <= 8) || motor_sel !== ((k <= 8) ? 3'd5 : 3'd0)) begin
        errors++; $display("FAIL jam motor cyc%0d: on=%b sel=%0d want on=%b", k, motor_on, motor_sel, (k <= 8));
      end
      checks++;
      if (fault !== (k >= 25)) begin
        errors++; $display("FAIL jam fault cyc%0d: got %b want %b", k, fault, (k >= 25));
      end
    end
    checks++;
    if (fault_code !== 2'b01 || change_owed !== 3'd2 || req_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL jam status: code=%b owed=%0d ready=%b done=%b want 01 2 0 0", fault_code, change_owed, req_ready, done);
    end
    clear_fault();
    checks++;
    if ({req_ready, motor_on, motor_sel, hopper_pulse, done, fault, fault_code, change_owed} !== 13'b1_0_000_0_0_0_00_000) begin
      errors++;
      $display("FAIL jam cleared: ready=%b motor=%b sel=%0d pulse=%b done=%b fault=%b code=%b owed=%0d want ready=1 rest 0",
               req_ready, motor_on, motor_sel, hopper_pulse, done, fault, fault_code, change_owed);
    end
  endtask

  task automatic test_hopper_empty();
    accept(3'd1, 3'd3, "hopper_empty");
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      drop_sense = (k == 2);
      if (k == 11) hopper_empty = 1'b1;
      checks++;
      if (hopper_pulse !== (k == 9 || k == 10)) begin
        errors++; $display("FAIL hopper_empty pulse cyc%0d: got %b want %b", k, hopper_pulse, (k == 9 || k == 10));
      end
      checks++;
      if (fault !== (k >= 13) || done !== 1'b0) begin
        errors++; $display("FAIL hopper_empty fault/done cyc%0d: fault=%b done=%b want fault=%b done=0", k, fault, done, (k >= 13));
      end
    end
    checks++;
    if (fault_code !== 2'b10 || change_owed !== 3'd2) begin
      errors++; $display("FAIL hopper_empty status: code=%b owed=%0d want 10 2", fault_code, change_owed);
    end
    hopper_empty = 1'b0;
    clear_fault();
  endtask

  task automatic test_bad_prod();
    accept(3'd7, 3'd4, "bad_prod");
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b11 || change_owed !== 3'd4 || motor_on !== 1'b0) begin
      errors++; $display("FAIL bad_prod status: fault=%b code=%b owed=%0d motor=%b want 1 11 4 0", fault, fault_code, change_owed, motor_on);
    end
    clear_fault();
    checks++;
    if (req_ready !== 1'b1 || fault !== 1'b0) begin
      errors++; $display("FAIL bad_prod cleared: ready=%b fault=%b want 1 0", req_ready, fault);
    end
  endtask

  task automatic test_busy_request();
    accept(3'd3, 3'd0, "busy");
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      drop_sense = (k == 3);
      if (k == 2) begin req_valid = 1'b1; req_prod = 3'd1; req_change = 3'd5; end
      if (k == 6) begin req_valid = 1'b0; req_prod = 3'd0; req_change = 3'd0; end
      if (k == 2) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL busy ready cyc2: got %b want 0", req_ready);
        end
      end
      checks++;
      if (motor_sel !== ((k <= 8) ? 3'd3 : 3'd0) || hopper_pulse !== 1'b0) begin
        errors++; $display("FAIL busy sel cyc%0d: sel=%0d pulse=%b want sel=%0d pulse=0", k, motor_sel, hopper_pulse, (k <= 8) ? 3 : 0);
      end
      checks++;
      if (done !== (k == 9)) begin
        errors++; $display("FAIL busy done cyc%0d: got %b want %b", k, done, (k == 9));
      end
    end
    drop_sense = 1'b0;
  endtask

  task automatic test_reset_mid();
    accept(3'd0, 3'd2, "reset_mid");
    checks++;
    if (hopper_pulse !== 1'b1) begin
      errors++; $display("FAIL reset_mid pulse_before: got %b want 1", hopper_pulse);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (hopper_pulse !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid async: pulse=%b ready=%b done=%b want 0 1 0", hopper_pulse, req_ready, done);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || change_owed !== 3'd0 || done !== 1'b0 || hopper_pulse !== 1'b0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid after cyc%0d: ready=%b owed=%0d done=%b pulse=%b fault=%b want 1 0 0 0 0",
                 k, req_ready, change_owed, done, hopper_pulse, fault);
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_prod = 3'd0; req_change = 3'd0;
    drop_sense = 1'b0; hopper_empty = 1'b0; fault_clr = 1'b0;
    test_reset();
    test_change_only();
    test_product_drop();
    test_jam();
    test_hopper_empty();
    test_bad_prod();
    test_busy_request();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
